// File: rtl/accum_alu.sv
// accum_alu: single-stage ALU with a running accumulator, a valid/ready
// handshake on both sides, and a count of accepted requests.
module accum_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             err,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned EXT_W = WIDTH + 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADDS = 3'd2,
    OP_ACC  = 3'd3,
    OP_ACCS = 3'd4,
    OP_CLR  = 3'd5
  } op_e;

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  logic             accept;
  logic [EXT_W-1:0] sum_ab;
  logic [EXT_W-1:0] diff_ab;
  logic [EXT_W-1:0] sum_acc;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic             nxt_err;
  logic [WIDTH-1:0] nxt_acc;

  // The result slot frees up when it is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Operation datapath; accumulator ops read the live register so
  // back-to-back accumulates always chain on the latest value.
  always_comb begin
    sum_ab     = EXT_W'(a) + EXT_W'(b);
    diff_ab    = EXT_W'(a) - EXT_W'(b);
    sum_acc    = EXT_W'(acc) + EXT_W'(a);
    nxt_result = '0;
    nxt_carry  = 1'b0;
    nxt_err    = 1'b0;
    nxt_acc    = acc;
    case (op)
      OP_ADD: begin
        nxt_result = sum_ab[WIDTH-1:0];
        nxt_carry  = sum_ab[WIDTH];
      end
      OP_SUB: begin
        nxt_result = diff_ab[WIDTH-1:0];
        nxt_carry  = diff_ab[WIDTH];
      end
      OP_ADDS: begin
        nxt_carry  = sum_ab[WIDTH];
        nxt_result = sum_ab[WIDTH] ? MAX_VAL : sum_ab[WIDTH-1:0];
      end
      OP_ACC: begin
        nxt_acc    = sum_acc[WIDTH-1:0];
        nxt_result = sum_acc[WIDTH-1:0];
        nxt_carry  = sum_acc[WIDTH];
      end
      OP_ACCS: begin
        nxt_carry  = sum_acc[WIDTH];
        nxt_acc    = sum_acc[WIDTH] ? MAX_VAL : sum_acc[WIDTH-1:0];
        nxt_result = sum_acc[WIDTH] ? MAX_VAL : sum_acc[WIDTH-1:0];
      end
      OP_CLR: begin
        nxt_acc    = '0;
      end
      default: begin
        nxt_err    = 1'b1;
      end
    endcase
  end

  // Result register, accumulator and request counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      count     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= nxt_result;
      carry     <= nxt_carry;
      err       <= nxt_err;
      acc       <= nxt_acc;
      count     <= count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accum_alu.sv
// Scoreboard bench for accum_alu (WIDTH=8, CNT_W=8).
module tb_accum_alu;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       e;
    logic [7:0] acc;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       err;
  logic [7:0] acc;
  logic [7:0] count;

  int unsigned n_cmp;
  int unsigned n_fail;

  exp_t        sb[$];
  exp_t        mx;
  int unsigned m_acc;
  int unsigned m_cnt;
  logic        m_ov;

  accum_alu #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .err       (err),
    .acc       (acc),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  task automatic model(input int unsigned o, input int unsigned av, input int unsigned bv, output exp_t x);
    int unsigned s;
    x.res = 8'd0;
    x.c   = 1'b0;
    x.e   = 1'b0;
    case (o)
      0: begin s = av + bv; x.res = 8'(s % 256); x.c = (s > 255); end
      1: begin x.res = 8'((av + 256 - bv) % 256); x.c = (av < bv); end
      2: begin s = av + bv; x.c = (s > 255); x.res = x.c ? 8'd255 : 8'(s); end
      3: begin s = m_acc + av; x.c = (s > 255); m_acc = s % 256; x.res = 8'(m_acc); end
      4: begin s = m_acc + av; x.c = (s > 255); m_acc = x.c ? 255 : s; x.res = 8'(m_acc); end
      5: begin m_acc = 0; end
      default: x.e = 1'b1;
    endcase
    m_cnt = (m_cnt + 1) % 256;
    x.acc = 8'(m_acc);
    x.cnt = 8'(m_cnt);
  endtask

  // One clock of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic cycle(input logic iv, input int unsigned o, input int unsigned av,
                       input int unsigned bv, input logic ordy);
    exp_t x;
    logic rdy;
    in_valid  = iv;
    op        = 3'(o);
    a         = 8'(av);
    b         = 8'(bv);
    out_ready = ordy;
    @(negedge clk);
    rdy = !m_ov || ordy;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (iv && rdy) begin
      model(o, av, bv, x);
      sb.push_back(x);
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cyc);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    op        = 3'd3;
    a         = 8'd7;
    b         = 8'd7;
    out_ready = 1'b1;
    repeat (cyc) @(posedge clk);
    #1;
    sb.delete();
    m_acc = 0;
    m_cnt = 0;
    m_ov  = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      int unsigned av;
      int unsigned bv;
      av = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 255);
      bv = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 255);
      cycle(($urandom_range(0, 9) < 8), $urandom_range(0, 7), av, bv, ($urandom_range(0, 9) < 7));
    end
  endtask

  // Monitor: checks every presented result against the scoreboard head and
  // retires it when the consumer takes it.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_empty: out_valid=1 with no expected result (t=%0t)", $time);
      end else begin
        mx = sb[0];
        chk("result", 32'(result), 32'(mx.res));
        chk("carry", 32'(carry), 32'(mx.c));
        chk("err", 32'(err), 32'(mx.e));
        chk("acc", 32'(acc), 32'(mx.acc));
        chk("count", 32'(count), 32'(mx.cnt));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    m_acc  = 0;
    m_cnt  = 0;
    m_ov   = 1'b0;
    do_reset(2);

    // Basic arithmetic with fixed expectations.
    cycle(1'b1, 0, 200, 100, 1'b1);
    chk("add_res", 32'(result), 32'd44);
    chk("add_c", 32'(carry), 32'd1);
    chk("add_valid", 32'(out_valid), 32'd1);
    cycle(1'b1, 1, 5, 7, 1'b1);
    chk("sub_res", 32'(result), 32'd254);
    chk("sub_c", 32'(carry), 32'd1);
    cycle(1'b1, 2, 200, 100, 1'b1);
    chk("adds_res", 32'(result), 32'd255);
    chk("adds_c", 32'(carry), 32'd1);
    cycle(1'b1, 2, 10, 20, 1'b1);
    chk("adds2_res", 32'(result), 32'd30);
    chk("adds2_c", 32'(carry), 32'd0);

    // Chained accumulation.
    cycle(1'b1, 5, 0, 0, 1'b1);
    chk("clr_acc", 32'(acc), 32'd0);
    cycle(1'b1, 3, 100, 0, 1'b1);
    chk("acc1", 32'(result), 32'd100);
    cycle(1'b1, 3, 100, 0, 1'b1);
    chk("acc2", 32'(result), 32'd200);
    cycle(1'b1, 3, 100, 0, 1'b1);
    chk("acc3", 32'(result), 32'd44);
    chk("acc3_c", 32'(carry), 32'd1);
    chk("acc3_acc", 32'(acc), 32'd44);
    cycle(1'b1, 4, 250, 0, 1'b1);
    chk("accs_res", 32'(result), 32'd255);
    chk("accs_c", 32'(carry), 32'd1);

    // Reserved op.
    cycle(1'b1, 6, 3, 4, 1'b1);
    chk("rsv_res", 32'(result), 32'd0);
    chk("rsv_err", 32'(err), 32'd1);
    chk("rsv_acc", 32'(acc), 32'd255);
    chk("rsv_count", 32'(count), 32'd10);

    // Backpressure.
    cycle(1'b0, 0, 0, 0, 1'b1);
    cycle(1'b1, 0, 1, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 0, 9, 9, 1'b0);
      chk("bp_res", 32'(result), 32'd2);
      chk("bp_count", 32'(count), 32'd11);
    end
    cycle(1'b1, 1, 9, 3, 1'b1);
    chk("bp_release_res", 32'(result), 32'd6);
    chk("bp_release_count", 32'(count), 32'd12);

    // Random traffic long enough to wrap the counter.
    rand_phase(700);

    // Reset with a pending result and a request on the input.
    cycle(1'b1, 0, 1, 2, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset(1);
    rand_phase(300);

    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 0, 1'b1);
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_alu.md
ACCUM_ALU -- requirements
Module: accum_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand, result and accumulator width; legal range 4..32.
REQ-002 Parameter CNT_W, default 8: width of the transaction counter.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1: reset, synchronous, active-low.
REQ-005 Port in_valid  in  1: operation request valid.
REQ-006 Port in_ready  out  1: block can accept a request this cycle.
REQ-007 Port op  in  3: operation code, see REQ-012.
REQ-008 Port a  in  WIDTH: operand A, unsigned.
REQ-009 Port b  in  WIDTH: operand B, unsigned.
REQ-010 Port out_valid  out  1: result register holds an unconsumed result.
REQ-011 Port out_ready  in  1: consumer accepts the result.
REQ-011a Port result  out  WIDTH: registered result.
REQ-011b Port carry  out  1: registered carry/borrow/saturation flag for the result.
REQ-011c Port err  out  1: registered, set for a reserved op code.
REQ-011d Port acc  out  WIDTH: current accumulator value.
REQ-011e Port count  out  CNT_W: number of accepted requests, modulo 2^CNT_W.

Function
REQ-012 op codes SHALL be: 0 ADD result=a+b mod 2^WIDTH, carry=bit WIDTH of sum; 1 SUB result=a-b mod 2^WIDTH, carry=borrow (a<b); 2 ADDS saturating: result=min(a+b, 2^WIDTH-1), carry=1 iff clamped; 3 ACC acc<=acc+a mod 2^WIDTH, result=new acc, carry=overflow; 4 ACCS acc<=min(acc+a, 2^WIDTH-1), result=new acc, carry=1 iff clamped; 5 CLR acc<=0, result=0, carry=0; 6,7 reserved: result=0, carry=0, err=1, acc unchanged.
REQ-013 err SHALL be 0 for ops 0-5.
REQ-014 A request SHALL be accepted in a cycle where in_valid=1 and in_ready=1 ("accept").
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-016 On accept, result, carry and err SHALL be registered and out_valid SHALL be 1 in the next cycle: latency exactly one cycle.
REQ-017 ACC/ACCS/CLR SHALL update acc at the accept edge; the new acc value SHALL be visible on acc in the same cycle out_valid rises.
REQ-018 ops 0,1,2 and reserved ops SHALL not modify acc.
REQ-019 out_valid SHALL clear on a cycle with out_valid=1, out_ready=1 and no accept; on simultaneous consume and accept it SHALL stay 1 with the new result loaded (full throughput, one result per cycle).
REQ-020 While out_valid=1 and out_ready=0, result, carry and err SHALL hold stable and no request SHALL be accepted.
REQ-021 Inputs op, a, b SHALL be ignored when no accept occurs.
REQ-022 count SHALL increment by 1 on every accept, including reserved ops, wrapping from 2^CNT_W-1 to 0.
REQ-023 Back-to-back ACC accepts SHALL use the acc value produced by the previous accept (no stale read).

Reset
REQ-024 When rst_n=0 at a rising clk edge: out_valid=0, result=0, carry=0, err=0, acc=0, count=0 after that edge.
REQ-025 Reset SHALL override any simultaneous accept or consume; a pending result SHALL be discarded.
REQ-026 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-027 WIDTH=8: ADD a=200 b=100 -> next cycle out_valid=1, result=44, carry=1; SUB a=5 b=7 -> result=254, carry=1.
REQ-028 ADDS a=200 b=100 -> result=255, carry=1; ADDS a=10 b=20 -> result=30, carry=0.
REQ-029 CLR, then ACC a=100 x3 back-to-back with out_ready=1 -> results 100, 200, 44 (carry=1 on third), acc=44; ACCS a=250 -> result 255, carry=1.
REQ-030 Backpressure: accept ADD 1+1, hold out_ready=0 four cycles with in_valid=1 -> in_ready=0, result=2 stable, count unchanged; raise out_ready -> next request accepted that cycle.
REQ-031 op=6 a=3 b=4 -> result=0, err=1, acc unchanged, count incremented; CNT_W=8 after 256 accepts count wraps to 0.
REQ-032 Assert rst_n=0 while out_valid=1 and in_valid=1 -> after edge out_valid=0, acc=0, count=0, in_ready=1 once released.
